lbox128_seq: RTL and testbench
==============================

// Module: lbox128_seq
// PURPOSE
//  Sequential forward Spook L-box over the 128-bit Shadow state; the encrypt-direction counterpart of the inverse L-box.
//  Applies the 2x32-bit L-box to column pairs (W0,W1) and (W2,W3) with one shared core, under a valid/ready handshake.
//  Sits between the S-box layer and the round-constant/D-box stage of the iterative Shadow round.
// PARAMETERS
//  UNROLL  1  L-box core instances: 1 = two passes (2-cycle compute), 2 = both pairs in one cycle
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    asynchronous, active-high reset
//  in_valid   in   1    sin carries a new state
//  in_ready   out  1    block can accept sin this cycle
//  sin        in   128  state in, column j = sin[127-32j -: 32]
//  out_valid  out  1    sout holds a finished result
//  out_ready  in   1    consumer takes sout this cycle
//  sout       out  128  L-box result, same column layout as sin
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, out_valid=0, sout=0, working regs=0; in_ready=0 while rst is high.
//  - Lane mapping: core word W_j = input column j with the bits of each byte reversed; output column j = core word with each byte bit-reversed.
//  - Core LB(x,y)->(a,b), rotr = rotate right on 32 bits:
//    a=x^rotr(x,12); b=y^rotr(y,12); a^=rotr(a,3); b^=rotr(b,3);
//    a^=rotr(x,17); b^=rotr(y,17); c=a^rotr(a,31); d=b^rotr(b,31);
//    a^=rotr(d,26); b^=rotr(c,25); a^=rotr(c,15); b^=rotr(d,15).
//  - FSM (UNROLL=1): IDLE -> P0 -> P1 -> DONE.
//    IDLE: in_ready=1; on in_valid latch the mapped words into W[0..3] -> P0.
//    P0: W0,W1 <= LB(W0,W1) -> P1.
//    P1: W2,W3 <= LB(W2,W3) -> DONE.
//    DONE: out_valid=1; sout is driven from registers and stays stable until the handshake.
//  - UNROLL=2: P0 updates both pairs, then DONE; P1 is unused.
//  - Latency: accept edge to out_valid=1 is 3 cycles (UNROLL=1) or 2 cycles (UNROLL=2).
//  - In DONE, in_ready=out_ready, so a new input can be accepted in the same cycle sout is taken.
//    - On out_ready & in_valid: latch the new input -> P0.
//    - On out_ready & !in_valid: -> IDLE.
//  - in_valid outside IDLE/DONE is ignored; no input is accepted and none is lost, because in_ready=0.
//  - out_valid drops the cycle after the out handshake unless a new result completes; it is never held off by a pending input.
//  - rst asserted mid-computation aborts the computation and returns to IDLE; no partial result is ever presented.
//  - All operations are XOR and rotation only; there is no width growth.
// STRUCTURE
//  - Shared package spook_pkg:
//    - STATE_W=128, WORD_W=32.
//    - The state enum {IDLE,P0,P1,DONE}.
//    - Functions byte_bitrev32() and rotr32().
//  - Sub-module lb32x2: combinational forward L-box on (x,y)->(a,b).
//    - Instantiated UNROLL times; for UNROLL=1 its input mux is selected by the state.
//  - Lane mapping and output de-mapping are combinational, outside the FSM.
// TESTING
//  1. sin=0, one transaction -> sout=0, out_valid exactly 3 cycles after accept (UNROLL=1) or 2 (UNROLL=2).
//  2. sin=all-ones -> sout=all-ones, because LB(FFFFFFFF,FFFFFFFF)=(FFFFFFFF,FFFFFFFF).
//  3. 1000 random sin compared with the C golden model.
//     Round trip: the inverse L-box of sout equals sin for every vector.
//  4. out_ready held low 10 cycles -> sout and out_valid stay stable and in_ready=0.
//     Release with in_valid=1 -> the next input is accepted in the same cycle.
//  5. Back-to-back stream, in_valid and out_ready always 1 -> one result every 3 cycles (UNROLL=1), results in order.
//  6. rst pulsed during P1 -> out_valid=0, sout=0, state IDLE.
//     The next transaction produces the correct result.

Source files
------------

// File: rtl/spook_pkg.sv
// Shared types and helpers for the Spook/Shadow L-box datapath.
package spook_pkg;

  localparam int STATE_W = 128;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    P0   = 2'd1,
    P1   = 2'd2,
    DONE = 2'd3
  } state_e;

  // Reverse the bit order inside each byte of a 32-bit word.
  function automatic logic [WORD_W-1:0] byte_bitrev32(input logic [WORD_W-1:0] w);
    logic [WORD_W-1:0] r;
    r = '0;
    for (int b = 0; b < 4; b++) begin
      for (int i = 0; i < 8; i++) begin
        r[8*b+i] = w[8*b+7-i];
      end
    end
    return r;
  endfunction

  // Rotate right on 32 bits; the doubled word keeps the shift free of wrap logic.
  function automatic logic [WORD_W-1:0] rotr32(input logic [WORD_W-1:0] x, input int unsigned n);
    logic [2*WORD_W-1:0] dbl;
    dbl = {x, x} >> n;
    return dbl[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/lbox128_seq_lb32x2.sv
// Combinational forward Spook L-box on one 2x32-bit column pair.
module lb32x2
  import spook_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic [WORD_W-1:0] a,
  output logic [WORD_W-1:0] b
);

  logic [WORD_W-1:0] ta;
  logic [WORD_W-1:0] tb;
  logic [WORD_W-1:0] c;
  logic [WORD_W-1:0] d;

  // XOR/rotate network; c and d are the cross-mixing terms between the two words.
  always_comb begin
    ta = x ^ rotr32(x, 12);
    tb = y ^ rotr32(y, 12);
    ta = ta ^ rotr32(ta, 3);
    tb = tb ^ rotr32(tb, 3);
    ta = ta ^ rotr32(x, 17);
    tb = tb ^ rotr32(y, 17);
    c  = ta ^ rotr32(ta, 31);
    d  = tb ^ rotr32(tb, 31);
    a  = ta ^ rotr32(d, 26) ^ rotr32(c, 15);
    b  = tb ^ rotr32(c, 25) ^ rotr32(d, 15);
  end

endmodule

// File: rtl/lbox128_seq.sv
// Sequential forward L-box over the 128-bit Shadow state with valid/ready handshake.
module lbox128_seq
  import spook_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] sin,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] sout
);

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  w_q [4];
  logic [WORD_W-1:0]  w_d [4];
  logic               out_valid_q, out_valid_d;
  logic [STATE_W-1:0] sout_q, sout_d;

  logic [WORD_W-1:0]  w_in [4];
  logic [WORD_W-1:0]  pair_a [2];
  logic [WORD_W-1:0]  pair_b [2];

  // Pack four core words back into the state layout, undoing the byte bit reversal.
  function automatic logic [STATE_W-1:0] demap(input logic [WORD_W-1:0] w0,
                                               input logic [WORD_W-1:0] w1,
                                               input logic [WORD_W-1:0] w2,
                                               input logic [WORD_W-1:0] w3);
    return {byte_bitrev32(w0), byte_bitrev32(w1), byte_bitrev32(w2), byte_bitrev32(w3)};
  endfunction

  // Lane mapping: column j of sin becomes core word j with each byte bit-reversed.
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      w_in[j] = byte_bitrev32(sin[STATE_W-1-WORD_W*j -: WORD_W]);
    end
  end

  generate
    if (UNROLL == 1) begin : g_shared
      logic [WORD_W-1:0] core_x, core_y, core_a, core_b;

      // One core serves both pairs; P1 steers it onto (W2,W3).
      always_comb begin
        core_x = (state_q == P1) ? w_q[2] : w_q[0];
        core_y = (state_q == P1) ? w_q[3] : w_q[1];
      end

      lb32x2 u_core (
        .x (core_x),
        .y (core_y),
        .a (core_a),
        .b (core_b)
      );

      // Both pair views see the same core; the state decides which one is consumed.
      always_comb begin
        pair_a[0] = core_a;
        pair_b[0] = core_b;
        pair_a[1] = core_a;
        pair_b[1] = core_b;
      end
    end else begin : g_unrolled
      for (genvar k = 0; k < 2; k++) begin : g_core
        lb32x2 u_core (
          .x (w_q[2*k]),
          .y (w_q[2*k+1]),
          .a (pair_a[k]),
          .b (pair_b[k])
        );
      end
    end
  endgenerate

  // Accept in IDLE, or in DONE when the current result leaves in the same cycle.
  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign out_valid = out_valid_q;
  assign sout      = sout_q;

  // Next-state, working-register and result computation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    sout_d      = sout_q;
    for (int j = 0; j < 4; j++) begin
      w_d[j] = w_q[j];
    end

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int j = 0; j < 4; j++) begin
            w_d[j] = w_in[j];
          end
          state_d = P0;
        end
      end
      P0: begin
        w_d[0] = pair_a[0];
        w_d[1] = pair_b[0];
        if (UNROLL == 2) begin
          w_d[2]      = pair_a[1];
          w_d[3]      = pair_b[1];
          sout_d      = demap(pair_a[0], pair_b[0], pair_a[1], pair_b[1]);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = P1;
        end
      end
      P1: begin
        w_d[2]      = pair_a[1];
        w_d[3]      = pair_b[1];
        sout_d      = demap(w_q[0], w_q[1], pair_a[1], pair_b[1]);
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            for (int j = 0; j < 4; j++) begin
              w_d[j] = w_in[j];
            end
            state_d = P0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working words and registered outputs; reset aborts any computation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      sout_q      <= '0;
      for (int j = 0; j < 4; j++) begin
        w_q[j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      sout_q      <= sout_d;
      for (int j = 0; j < 4; j++) begin
        w_q[j] <= w_d[j];
      end
    end
  end

endmodule

// File: tb/tb_lbox128_seq.sv
// Self-checking bench for lbox128_seq: behavioural L-box model, GF(2) inverse, scoreboard.
module tb_lbox128_seq;

  localparam int UNROLL = 1;
  localparam int LAT    = (UNROLL == 1) ? 3 : 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] sin;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] sout;

  always #5 clk = ~clk;

  lbox128_seq #(.UNROLL(UNROLL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sout      (sout)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [63:0] lb(input logic [31:0] x, input logic [31:0] y);
    logic [31:0] a, b, c, d;
    a = x ^ rr(x, 12); b = y ^ rr(y, 12);
    a ^= rr(a, 3);     b ^= rr(b, 3);
    a ^= rr(x, 17);    b ^= rr(y, 17);
    c = a ^ rr(a, 31); d = b ^ rr(b, 31);
    a ^= rr(d, 26);    b ^= rr(c, 25);
    a ^= rr(c, 15);    b ^= rr(d, 15);
    return {a, b};
  endfunction

  function automatic logic [31:0] brev(input logic [31:0] w);
    logic [31:0] r;
    for (int k = 0; k < 32; k++) r[(k / 8) * 8 + (7 - k % 8)] = w[k];
    return r;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s);
    logic [31:0]  w [4];
    logic [63:0]  p;
    logic [127:0] o;
    for (int j = 0; j < 4; j++) w[j] = brev(s[127-32*j -: 32]);
    o = '0;
    for (int q = 0; q < 2; q++) begin
      p = lb(w[2*q], w[2*q+1]);
      o[127-64*q -: 32] = brev(p[63:32]);
      o[95-64*q  -: 32] = brev(p[31:0]);
    end
    return o;
  endfunction

  // Inverse of the 64-bit linear map, built by Gaussian elimination over GF(2).
  logic [63:0] minv [64];

  task automatic build_inv();
    logic [63:0] m  [64];
    logic [63:0] id [64];
    logic [63:0] e, v, t;
    int piv;
    for (int c = 0; c < 64; c++) begin
      e = 64'd1 << c;
      v = lb(e[63:32], e[31:0]);
      for (int r = 0; r < 64; r++) m[r][c] = v[r];
    end
    for (int r = 0; r < 64; r++) id[r] = 64'd1 << r;
    for (int c = 0; c < 64; c++) begin
      piv = -1;
      for (int r = c; r < 64; r++) if (piv < 0 && m[r][c]) piv = r;
      if (piv < 0) begin
        check("lbox_invertible", 128'(c), 128'(64));
        break;
      end
      t = m[c]; m[c] = m[piv]; m[piv] = t;
      t = id[c]; id[c] = id[piv]; id[piv] = t;
      for (int r = 0; r < 64; r++) begin
        if (r != c && m[r][c]) begin
          m[r]  ^= m[c];
          id[r] ^= id[c];
        end
      end
    end
    for (int r = 0; r < 64; r++) minv[r] = id[r];
  endtask

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [63:0]  y, x;
    logic [127:0] o;
    o = '0;
    for (int q = 0; q < 2; q++) begin
      y = {brev(s[127-64*q -: 32]), brev(s[95-64*q -: 32])};
      for (int r = 0; r < 64; r++) x[r] = ^(minv[r] & y);
      o[127-64*q -: 32] = brev(x[63:32]);
      o[95-64*q  -: 32] = brev(x[31:0]);
    end
    return o;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [127:0] exp_q [$];
  logic [127:0] src_q [$];
  int           acc_q [$];
  int           out_cyc [$];

  always @(negedge clk) begin
    logic exp_valid, exp_ready;
    if (rst) begin
      exp_q.delete();
      src_q.delete();
      acc_q.delete();
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid", 128'(out_valid), 128'(0));
      check("rst_sout", sout, 128'(0));
    end else begin
      exp_valid = (acc_q.size() > 0) && (cyc - acc_q[0] >= LAT);
      exp_ready = (acc_q.size() == 0) ? 1'b1 : (exp_valid && out_ready);
      check("in_ready", 128'(in_ready), 128'(exp_ready));
      check("out_valid", 128'(out_valid), 128'(exp_valid));
      if (exp_valid) begin
        check("sout", sout, exp_q[0]);
        if (out_ready) begin
          check("roundtrip", inv_state(sout), src_q[0]);
          void'(exp_q.pop_front());
          void'(src_q.pop_front());
          void'(acc_q.pop_front());
          out_cyc.push_back(cyc);
        end
      end
      if (in_valid && exp_ready) begin
        exp_q.push_back(model(sin));
        src_q.push_back(sin);
        acc_q.push_back(cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] d);
    logic got;
    int n;
    in_valid = 1'b1;
    sin      = d;
    n        = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!got && n < 50);
    if (!got) check("send_timeout", 128'(0), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) check("out_timeout", 128'(0), 128'(1));
  endtask

  localparam logic [127:0] E0_IN  = {32'h0000_0080, 96'h0};
  localparam logic [127:0] E0_OUT = {32'h0428_0276, 32'hD803_800D, 64'h0};

  initial begin
    logic [127:0] v;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sin       = '0;
    build_inv();

    // Hand-computed anchors for the model itself.
    check("model_zero", model('0), '0);
    check("model_ones", model('1), '1);
    check("model_e0", model(E0_IN), E0_OUT);
    check("inv_e0", inv_state(E0_OUT), E0_IN);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // All-zero, all-ones and single-bit directed vectors.
    send('0);
    wait_out();
    check("t1_zero", sout, '0);
    @(posedge clk); #1;
    send('1);
    wait_out();
    check("t2_ones", sout, '1);
    @(posedge clk); #1;
    send(E0_IN);
    wait_out();
    check("t_e0", sout, E0_OUT);
    @(posedge clk); #1;

    // Consumer stall, then same-cycle take and accept.
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom});
    wait_out();
    @(posedge clk); #1;
    in_valid = 1'b1;
    sin      = {$urandom, $urandom, $urandom, $urandom};
    repeat (10) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("t4_accept_on_take", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out();
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    // Back-to-back stream: one result every LAT cycles.
    out_cyc.delete();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    repeat (300) begin
      sin = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("t5_count", 128'(out_cyc.size() >= 90), 128'(1));
    for (int i = 1; i < out_cyc.size(); i++)
      check("t5_period", 128'(out_cyc[i] - out_cyc[i-1]), 128'(LAT));

    // Random handshakes on both sides.
    repeat (2000) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      sin       = {$urandom, $urandom, $urandom, $urandom};
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // Reset in the middle of the second pass.
    send({$urandom, $urandom, $urandom, $urandom});
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_out_valid", 128'(out_valid), 128'(0));
    check("t6_sout", sout, '0);
    check("t6_idle", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    v = {$urandom, $urandom, $urandom, $urandom};
    send(v);
    wait_out();
    check("t6_after", sout, model(v));
    @(posedge clk); #1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
